// File: rtl/periph_pkg.sv
// Shared definitions for the MMIO peripheral hub: register offsets, bit positions
// and the default window base.
package periph_pkg;

    localparam logic [31:0] DEFAULT_BASE = 32'hFFFF_FF00;

    localparam logic [7:0] OFF_LED_DATA = 8'h00;
    localparam logic [7:0] OFF_LED_MODE = 8'h04;
    localparam logic [7:0] OFF_SW       = 8'h08;
    localparam logic [7:0] OFF_CNT_LO   = 8'h0C;
    localparam logic [7:0] OFF_CNT_HI   = 8'h10;
    localparam logic [7:0] OFF_CNT_CTRL = 8'h14;
    localparam logic [7:0] OFF_TX_DATA  = 8'h18;
    localparam logic [7:0] OFF_TX_STAT  = 8'h1C;

    localparam int CNT_CTRL_CLEAR = 0;
    localparam int CNT_CTRL_EN    = 1;

    localparam int TX_STAT_FULL    = 0;
    localparam int TX_STAT_EMPTY   = 1;
    localparam int TX_STAT_OVF     = 2;
    localparam int TX_STAT_OCC_LSB = 8;

    // Word-aligned register offset; the byte lane bits are ignored.
    function automatic logic [7:0] word_offset(input logic [7:0] byte_addr);
        return {byte_addr[7:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count and a sticky overflow flag.
// The head entry is presented combinationally from storage and reads 0 when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       ovf_clr_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       ovf_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign head_o  = empty_o ? '0 : mem[rd_ptr_q];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push_i && !push_ok) ovf_d = 1'b1;
        else if (ovf_clr_i)     ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: storage has no reset; stale entries are unreachable because head_o is
    // masked by empty_o and the pointers/count are reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/mmio_periph_hub.sv
// Memory-mapped peripheral hub: LED bank with blink, synchronised switches,
// 64-bit cycle counter with high-word snapshot, and a byte TX FIFO.
module mmio_periph_hub
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE       = DEFAULT_BASE,
    parameter int unsigned NUM_LED    = 16,
    parameter int unsigned NUM_SW     = 8,
    parameter logic [23:0] BLINK_DIV  = 24'd5_000_000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        addr,
    input  logic               we,
    input  logic               re,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               hit,
    input  logic [NUM_SW-1:0]  sw,
    output logic [NUM_LED-1:0] led,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0] off;
    logic       wr_sel, rd_sel;
    logic       wr_led_data, wr_led_mode, wr_cnt_ctrl, wr_tx_data;
    logic       rd_cnt_lo, rd_tx_stat;

    logic [NUM_LED-1:0] led_data_q, led_data_d;
    logic               blink_en_q, blink_en_d;
    logic [23:0]        div_q, div_d;
    logic               phase_q, phase_d;
    logic [63:0]        cnt_q, cnt_d;
    logic               cnt_en_q, cnt_en_d;
    logic [31:0]        snap_hi_q, snap_hi_d;
    logic [NUM_SW-1:0]  sw_meta_q, sw_sync_q;

    logic          fifo_full, fifo_empty, fifo_ovf;
    logic [CW-1:0] fifo_count;
    logic          unused_bits;

    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    assign hit    = (addr[31:8] == BASE[31:8]);
    assign off    = word_offset(addr[7:0]);
    assign wr_sel = we & hit;
    assign rd_sel = re & hit;

    assign wr_led_data = wr_sel && (off == OFF_LED_DATA);
    assign wr_led_mode = wr_sel && (off == OFF_LED_MODE);
    assign wr_cnt_ctrl = wr_sel && (off == OFF_CNT_CTRL);
    assign wr_tx_data  = wr_sel && (off == OFF_TX_DATA);
    assign rd_cnt_lo   = rd_sel && (off == OFF_CNT_LO);
    assign rd_tx_stat  = rd_sel && (off == OFF_TX_STAT);

    // NOTE: every combinational output gets its default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        led_data_d = led_data_q;
        blink_en_d = blink_en_q;
        div_d      = div_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        cnt_en_d   = cnt_en_q;
        snap_hi_d  = snap_hi_q;

        if (wr_led_data) led_data_d = wdata[NUM_LED-1:0];

        // Any LED_MODE write restarts the blink so the first half-period is lit.
        if (wr_led_mode) begin
            blink_en_d = wdata[0];
            div_d      = '0;
            phase_d    = 1'b1;
        end else if (blink_en_q) begin
            if (div_q == BLINK_DIV - 24'd1) begin
                div_d   = '0;
                phase_d = ~phase_q;
            end else begin
                div_d = div_q + 24'd1;
            end
        end

        if (wr_cnt_ctrl) cnt_en_d = wdata[CNT_CTRL_EN];
        if (wr_cnt_ctrl && wdata[CNT_CTRL_CLEAR]) cnt_d = '0;
        else if (cnt_en_q)                        cnt_d = cnt_q + 64'd1;

        if (rd_cnt_lo) snap_hi_d = cnt_q[63:32];
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_data_q <= '0;
            blink_en_q <= 1'b0;
            div_q      <= '0;
            phase_q    <= 1'b1;
            cnt_q      <= '0;
            cnt_en_q   <= 1'b1;
            snap_hi_q  <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            led_data_q <= led_data_d;
            blink_en_q <= blink_en_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            cnt_en_q   <= cnt_en_d;
            snap_hi_q  <= snap_hi_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
        end
    end

    assign led = (blink_en_q && !phase_q) ? '0 : led_data_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wr_tx_data),
        .push_data_i (wdata[7:0]),
        .pop_i       (tx_ready),
        .ovf_clr_i   (rd_tx_stat),
        .head_o      (tx_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .ovf_o       (fifo_ovf)
    );

    assign tx_valid = ~fifo_empty;

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_LED_DATA: rdata = 32'(led_data_q);
                OFF_LED_MODE: rdata[0] = blink_en_q;
                OFF_SW:       rdata = 32'(sw_sync_q);
                OFF_CNT_LO:   rdata = cnt_q[31:0];
                OFF_CNT_HI:   rdata = snap_hi_q;
                OFF_TX_STAT: begin
                    rdata[TX_STAT_FULL]                       = fifo_full;
                    rdata[TX_STAT_EMPTY]                      = fifo_empty;
                    rdata[TX_STAT_OVF]                        = fifo_ovf;
                    rdata[TX_STAT_OCC_LSB+7:TX_STAT_OCC_LSB] = 8'(fifo_count);
                end
                default:      rdata = '0;
            endcase
        end
    end

endmodule
